// File: rtl/bp_pkg.sv
// Shared types and counter helpers for the gshare branch predictor.
package bp_pkg;

  typedef enum logic {INIT, RUN} bp_state_e;

  // Counter helpers work on up to 8-bit counters; callers truncate to CTR_WIDTH.
  localparam int unsigned MAX_CTR_WIDTH = 8;

  // Weakly-not-taken encoding: 2^(w-1)-1.
  function automatic logic [MAX_CTR_WIDTH-1:0] weak_nt(int unsigned w);
    return MAX_CTR_WIDTH'((1 << (w - 1)) - 1);
  endfunction

  function automatic logic [MAX_CTR_WIDTH-1:0] sat_next(logic [MAX_CTR_WIDTH-1:0] ctr,
                                                        logic taken, int unsigned w);
    logic [MAX_CTR_WIDTH-1:0] max_val;
    max_val = MAX_CTR_WIDTH'((1 << w) - 1);
    if (taken) begin
      return (ctr >= max_val) ? max_val : ctr + 1'b1;
    end
    return (ctr == '0) ? '0 : ctr - 1'b1;
  endfunction

endpackage

// File: rtl/pht_ram.sv
// Pattern history table: async read for prediction, one sync write port that either
// stores the init value or applies a saturating train step to the addressed counter.
module pht_ram
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic [INDEX_BITS-1:0] rd_addr,
  output logic [CTR_WIDTH-1:0]  rd_data,
  input  logic                  wr_en,
  input  logic                  wr_init,
  input  logic [INDEX_BITS-1:0] wr_addr,
  input  logic                  wr_taken
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_WIDTH-1:0] WEAK_NT = CTR_WIDTH'(weak_nt(CTR_WIDTH));

  logic [CTR_WIDTH-1:0] mem [ENTRIES];
  logic [CTR_WIDTH-1:0] wr_cur;
  logic [CTR_WIDTH-1:0] wr_data;

  assign rd_data = mem[rd_addr];
  assign wr_cur  = mem[wr_addr];

  always_comb begin
    wr_data = WEAK_NT;
    if (!wr_init) begin
      wr_data = CTR_WIDTH'(sat_next(MAX_CTR_WIDTH'(wr_cur), wr_taken, CTR_WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/branch_predictor_ctrl.sv
// Gshare direction predictor: PHT init sweep, per-cycle prediction, training and
// speculative global history with repair on mispredict.
module branch_predictor_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CTR_WIDTH  = 2,
  parameter int unsigned PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  output logic                  ready,
  input  logic                  fetch_valid,
  input  logic [PC_WIDTH-1:0]   fetch_pc,
  output logic                  predict_taken,
  output logic [INDEX_BITS-1:0] predict_index,
  output logic [INDEX_BITS-1:0] predict_ghr,
  input  logic                  update_valid,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic                  update_taken,
  input  logic                  update_mispredict,
  input  logic [INDEX_BITS-1:0] update_ghr
);

  bp_state_e             state_q, state_d;
  logic [INDEX_BITS-1:0] init_ptr_q, init_ptr_d;
  logic [INDEX_BITS-1:0] ghr_q, ghr_d;

  logic [CTR_WIDTH-1:0]  rd_data;
  logic                  wr_en;
  logic                  wr_init;
  logic [INDEX_BITS-1:0] wr_addr;

  assign predict_index = fetch_pc[INDEX_BITS+1:2] ^ ghr_q;
  assign predict_ghr   = ghr_q;
  assign ready         = (state_q == RUN);
  assign predict_taken = (state_q == RUN) && rd_data[CTR_WIDTH-1];

  pht_ram #(
    .INDEX_BITS (INDEX_BITS),
    .CTR_WIDTH  (CTR_WIDTH)
  ) u_pht (
    .clk      (clk),
    .rd_addr  (predict_index),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_init  (wr_init),
    .wr_addr  (wr_addr),
    .wr_taken (update_taken)
  );

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    ghr_d      = ghr_q;
    wr_en      = 1'b0;
    wr_init    = 1'b0;
    wr_addr    = update_index;
    if (flush) begin
      state_d    = INIT;
      init_ptr_d = '0;
      ghr_d      = '0;
    end else begin
      unique case (state_q)
        INIT: begin
          wr_en      = 1'b1;
          wr_init    = 1'b1;
          wr_addr    = init_ptr_q;
          init_ptr_d = init_ptr_q + 1'b1;
          if (init_ptr_q == '1) begin
            state_d = RUN;
          end
        end
        RUN: begin
          wr_en = update_valid;
          // Repair takes precedence over the speculative shift of the same cycle.
          if (update_valid && update_mispredict) begin
            ghr_d = {update_ghr[INDEX_BITS-2:0], update_taken};
          end else if (fetch_valid) begin
            ghr_d = {ghr_q[INDEX_BITS-2:0], predict_taken};
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      ghr_q      <= ghr_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Directed bench for branch_predictor_ctrl: vector table plus init/flush/reset sequences.
module tb_branch_predictor_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        ready;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        predict_taken;
  logic [5:0]  predict_index;
  logic [5:0]  predict_ghr;
  logic        update_valid;
  logic [5:0]  update_index;
  logic        update_taken;
  logic        update_mispredict;
  logic [5:0]  update_ghr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_predictor_ctrl #(
    .INDEX_BITS (6),
    .CTR_WIDTH  (2),
    .PC_WIDTH   (32)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .flush             (flush),
    .ready             (ready),
    .fetch_valid       (fetch_valid),
    .fetch_pc          (fetch_pc),
    .predict_taken     (predict_taken),
    .predict_index     (predict_index),
    .predict_ghr       (predict_ghr),
    .update_valid      (update_valid),
    .update_index      (update_index),
    .update_taken      (update_taken),
    .update_mispredict (update_mispredict),
    .update_ghr        (update_ghr)
  );

  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic        uv;
    logic [5:0]  ui;
    logic        ut;
    logic        um;
    logic [5:0]  ug;
    logic        e_taken;
    logic [5:0]  e_idx;
    logic [5:0]  e_ghr;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush             = 1'b0;
    fetch_valid       = 1'b0;
    fetch_pc          = 32'h0;
    update_valid      = 1'b0;
    update_index      = 6'd0;
    update_taken      = 1'b0;
    update_mispredict = 1'b0;
    update_ghr        = 6'd0;
  endtask

  // Counts clock edges until ready rises, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic chk_all_weak(input string name);
    for (int i = 0; i < 64; i++) begin
      chk(name, 32'(dut.u_pht.mem[i]), 32'd1);
    end
  endtask

  initial begin
    int n;
    idle_inputs();
    reset_n = 1'b0;

    //                fv    pc      uv    ui     ut    um    ug      t     idx    ghr
    vecs[0]  = '{1'b0, 32'h14, 1'b1, 6'd5,  1'b1, 1'b0, 6'h00, 1'b0, 6'd5,  6'h00};
    vecs[1]  = '{1'b0, 32'h14, 1'b1, 6'd5,  1'b1, 1'b0, 6'h00, 1'b1, 6'd5,  6'h00};
    vecs[2]  = '{1'b0, 32'h14, 1'b1, 6'd5,  1'b1, 1'b0, 6'h00, 1'b1, 6'd5,  6'h00};
    vecs[3]  = '{1'b0, 32'h14, 1'b1, 6'd5,  1'b1, 1'b0, 6'h00, 1'b1, 6'd5,  6'h00};
    vecs[4]  = '{1'b0, 32'h14, 1'b1, 6'd5,  1'b0, 1'b0, 6'h00, 1'b1, 6'd5,  6'h00};
    vecs[5]  = '{1'b0, 32'h14, 1'b1, 6'd5,  1'b0, 1'b0, 6'h00, 1'b1, 6'd5,  6'h00};
    vecs[6]  = '{1'b0, 32'h14, 1'b1, 6'd5,  1'b0, 1'b0, 6'h00, 1'b0, 6'd5,  6'h00};
    vecs[7]  = '{1'b0, 32'h14, 1'b1, 6'd5,  1'b0, 1'b0, 6'h00, 1'b0, 6'd5,  6'h00};
    vecs[8]  = '{1'b0, 32'h14, 1'b0, 6'd5,  1'b0, 1'b0, 6'h00, 1'b0, 6'd5,  6'h00};
    vecs[9]  = '{1'b0, 32'h10, 1'b1, 6'd4,  1'b1, 1'b0, 6'h00, 1'b0, 6'd4,  6'h00};
    vecs[10] = '{1'b0, 32'h10, 1'b1, 6'd4,  1'b1, 1'b0, 6'h00, 1'b1, 6'd4,  6'h00};
    vecs[11] = '{1'b1, 32'h10, 1'b0, 6'd0,  1'b0, 1'b0, 6'h00, 1'b1, 6'd4,  6'h00};
    vecs[12] = '{1'b0, 32'h10, 1'b0, 6'd0,  1'b0, 1'b0, 6'h00, 1'b0, 6'd5,  6'h01};
    vecs[13] = '{1'b1, 32'h00, 1'b1, 6'd20, 1'b0, 1'b1, 6'h2A, 1'b0, 6'd1,  6'h01};
    vecs[14] = '{1'b0, 32'h00, 1'b0, 6'd0,  1'b0, 1'b0, 6'h00, 1'b0, 6'd20, 6'h14};
    vecs[15] = '{1'b0, 32'h00, 1'b1, 6'd20, 1'b1, 1'b0, 6'h00, 1'b0, 6'd20, 6'h14};
    vecs[16] = '{1'b0, 32'h00, 1'b1, 6'd20, 1'b1, 1'b0, 6'h00, 1'b0, 6'd20, 6'h14};
    vecs[17] = '{1'b0, 32'h00, 1'b0, 6'd0,  1'b0, 1'b0, 6'h00, 1'b1, 6'd20, 6'h14};

    // Reset values, with fetch activity that must not disturb INIT.
    fetch_pc    = 32'h14;
    fetch_valid = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_taken", 32'(predict_taken), 32'd0);
    chk("rst_index", 32'(predict_index), 32'd5);
    chk("rst_ghr", 32'(predict_ghr), 32'd0);
    reset_n = 1'b1;
    wait_ready(n);
    chk("init_len", 32'(n), 32'd64);
    chk("init_ghr", 32'(predict_ghr), 32'd0);
    fetch_valid = 1'b0;
    chk_all_weak("init_mem");
    for (int i = 0; i < 64; i++) begin
      fetch_pc = 32'(i) << 2;
      #1;
      chk("init_pred", 32'(predict_taken), 32'd0);
    end

    for (int i = 0; i < 18; i++) begin
      fetch_valid       = vecs[i].fv;
      fetch_pc          = vecs[i].pc;
      update_valid      = vecs[i].uv;
      update_index      = vecs[i].ui;
      update_taken      = vecs[i].ut;
      update_mispredict = vecs[i].um;
      update_ghr        = vecs[i].ug;
      #1;
      chk($sformatf("v%0d_taken", i), 32'(predict_taken), 32'(vecs[i].e_taken));
      chk($sformatf("v%0d_index", i), 32'(predict_index), 32'(vecs[i].e_idx));
      chk($sformatf("v%0d_ghr", i), 32'(predict_ghr), 32'(vecs[i].e_ghr));
      tick();
    end
    idle_inputs();

    // Flush from RUN, then again 10 cycles into the sweep, with updates pending throughout.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ready", 32'(ready), 32'd0);
    chk("flush_ghr", 32'(predict_ghr), 32'd0);
    update_valid      = 1'b1;
    update_index      = 6'd5;
    update_taken      = 1'b1;
    update_mispredict = 1'b1;
    update_ghr        = 6'h3F;
    fetch_valid       = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_init_ready", 32'(ready), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_ready(n);
    chk("reflush_len", 32'(n), 32'd64);
    idle_inputs();
    chk("reflush_ghr", 32'(predict_ghr), 32'd0);
    chk_all_weak("reflush_mem");

    // Async reset in RUN: values return without waiting for an edge.
    update_valid      = 1'b1;
    update_mispredict = 1'b1;
    update_taken      = 1'b1;
    update_ghr        = 6'h00;
    tick();
    idle_inputs();
    fetch_pc = 32'h10;
    #1;
    chk("pre_rst_ghr", 32'(predict_ghr), 32'd1);
    chk("pre_rst_index", 32'(predict_index), 32'd5);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 32'd0);
    chk("arst_ghr", 32'(predict_ghr), 32'd0);
    chk("arst_index", 32'(predict_index), 32'd4);
    tick();
    reset_n = 1'b1;
    wait_ready(n);
    chk("rerst_len", 32'(n), 32'd64);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor_ctrl.md
# branch_predictor_ctrl

Gshare direction-prediction controller for the pipelined core's fetch stage. Owns a pattern history table (PHT) of saturating counters and a global history register (GHR). Sequences table initialisation after reset or flush, serves one prediction per cycle to fetch, and applies one resolved-branch update per cycle from execute, including GHR repair on mispredict.

## Interface
Parameters:
- INDEX_BITS, 6, log2 of PHT entries; also the GHR length.
- CTR_WIDTH, 2, bits per saturating counter.
- PC_WIDTH, 32, fetch PC width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  re-initialise the PHT and clear the GHR.
- ready  out  1  1 when in RUN; 0 during INIT.
- fetch_valid  in  1  a prediction is consumed this cycle.
- fetch_pc  in  PC_WIDTH  PC of the fetched instruction.
- predict_taken  out  1  predicted direction.
- predict_index  out  INDEX_BITS  PHT index used; carried down the pipe.
- predict_ghr  out  INDEX_BITS  GHR value before the speculative shift; carried down the pipe.
- update_valid  in  1  a resolved branch is reported.
- update_index  in  INDEX_BITS  PHT entry to train.
- update_taken  in  1  actual outcome.
- update_mispredict  in  1  prediction was wrong; repair the GHR.
- update_ghr  in  INDEX_BITS  GHR captured at that branch's prediction.

## Operation
- index = fetch_pc[INDEX_BITS+1:2] XOR ghr. All outputs are combinational from the current state and table.
- predict_taken = MSB of PHT[index] when in RUN. It is forced to 0 in INIT.
- States:
  - INIT: write WEAK_NT = 2^(CTR_WIDTH-1)-1 to PHT[init_ptr]; init_ptr += 1. When init_ptr = 2^INDEX_BITS-1 and that write completes, go to RUN.
  - RUN: serve predictions and updates.
  - flush in either state: go to INIT, set init_ptr = 0, set ghr = 0. Flush has priority over everything else.
- Speculative history: in RUN, fetch_valid=1 shifts predict_taken into the GHR, ghr <= {ghr[INDEX_BITS-2:0], predict_taken}.
- Training: in RUN, update_valid=1 changes PHT[update_index] saturating. Increment if taken, decrement if not. The counter holds at 2^CTR_WIDTH-1 on taken and holds at 0 on not-taken. There is no wrap.
- Repair: update_valid & update_mispredict sets ghr <= {update_ghr[INDEX_BITS-2:0], update_taken}. This overrides a same-cycle fetch shift.
- Same-cycle fetch and update to the same index: the prediction uses the pre-update value. There is no bypass.
- In INIT, fetch_valid and update_valid are ignored.

## Timing
- Reset values:
  - state = INIT, init_ptr = 0, ghr = 0.
  - ready = 0, predict_taken = 0, predict_index = fetch_pc bits XOR 0, predict_ghr = 0.
  - PHT contents are undefined until swept.
- Latency:
  - INIT lasts exactly 2^INDEX_BITS cycles after reset_n deasserts or after the flush cycle. ready is 1 in the following cycle.
  - A prediction is available in the same cycle as fetch_pc.
  - An update is visible to a prediction one cycle later.
  - GHR repair is visible to the next cycle's index.
- reset_n asserted mid-INIT or mid-RUN: immediate return to the reset values.
- flush during INIT restarts the sweep from entry 0.

## Structure
- Shared package bp_pkg:
  - state enum {INIT, RUN}.
  - WEAK_NT constant, a function of CTR_WIDTH.
  - sat_next(ctr, taken) function.
- One sub-module, pht_ram:
  - 2^INDEX_BITS × CTR_WIDTH array, no reset.
  - One asynchronous read port and one synchronous write port.
  - The write port is muxed between the INIT sweep and RUN training.

## Test plan
- Reset, INDEX_BITS=6 -> ready=0 for 64 cycles, then 1. Every index predicts 0; a read-back of every entry gives 1 (WEAK_NT).
- Entry 5: three taken updates -> predict 0,1,1 at successive reads; counter 1→2→3→3 (saturates). Four not-taken updates -> 3→2→1→0→0.
- Fetch fetch_pc=0x10 with ghr=0 and entry trained to 3 -> predict_taken=1, predict_index=4; next cycle ghr=1.
- Same cycle: fetch_valid=1 and update_mispredict=1 with update_ghr=0x2A, update_taken=0 -> ghr=0x14 (repair wins over the fetch shift).
- flush asserted 10 cycles into the INIT sweep -> ready stays 0 for a full 64 cycles after the flush. Updates during INIT leave entries at 1.
- reset_n pulsed low mid-RUN -> ready=0 and ghr=0 immediately, then the full 64-cycle INIT sweep runs again.
